// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// Define EX_MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU raise op_err.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mf_req,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            op_err,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [CW-1:0]     cnt;
    logic              is_div, neg_lo, neg_hi;

    assign busy  = (state != IDLE);
    assign stall = busy & (start | mf_req);

    // Signedness comes from op[0] for both MULT/MULTU and DIV/DIVU.
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    assign a_neg = ~op[0] & a[XLEN-1];
    assign b_neg = ~op[0] & b[XLEN-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    // Shift-add: acc holds {partial sum, remaining multiplier bits}.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, step;
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

`ifdef EX_MULDIV_DIV_EN
    // Restoring: acc holds {remainder, dividend bits shifting into quotient}.
    logic [XLEN:0]     rem_sh, diff;
    logic [2*XLEN-1:0] div_next;
    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign diff     = rem_sh - {1'b0, opnd};
    assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
`endif

    always_comb begin
        step = mul_next;
`ifdef EX_MULDIV_DIV_EN
        if (is_div) step = div_next;
`endif
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_hi, fix_lo;
    assign prod = neg_lo ? -acc : acc;
    always_comb begin
        {fix_hi, fix_lo} = prod;
        if (is_div) begin
            fix_lo = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            fix_hi = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            op_err <= 1'b0;
        end else begin
            done   <= 1'b0;
            op_err <= 1'b0;
            case (state)
                IDLE: if (start && !flush) begin
                    case (op)
                        3'b000, 3'b001: begin
                            acc    <= {{XLEN{1'b0}}, b_abs};
                            opnd   <= a_abs;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= 1'b0;
                            is_div <= 1'b0;
                            cnt    <= CW'(XLEN - 1);
                            state  <= RUN;
                        end
`ifdef EX_MULDIV_DIV_EN
                        // A zero divisor yields all-ones quotient and |a| remainder;
                        // giving the remainder a's sign reproduces hi = a.
                        3'b010, 3'b011: begin
                            acc    <= {{XLEN{1'b0}}, a_abs};
                            opnd   <= b_abs;
                            neg_lo <= (a_neg ^ b_neg) & (b != '0);
                            neg_hi <= a_neg;
                            is_div <= 1'b1;
                            cnt    <= CW'(XLEN - 1);
                            state  <= RUN;
                        end
`endif
                        3'b100:  hi <= a;
                        3'b101:  lo <= a;
                        default: op_err <= 1'b1;
                    endcase
                end
                RUN: begin
                    if (flush) state <= IDLE;
                    else begin
                        acc <= step;
                        if (cnt == '0) state <= FIX;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases then random ops
// checked against an arithmetic model of HI/LO.
module tb_ex_muldiv_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0, rst = 1'b1;
    logic            start = 1'b0, mf_req = 1'b0, flush = 1'b0;
    logic [2:0]      op = 3'b000;
    logic [XLEN-1:0] a = '0, b = '0;
    logic            busy, stall, done, op_err;
    logic [XLEN-1:0] hi, lo;

    int nvec = 0, nerr = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    ex_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mf_req(mf_req), .flush(flush), .busy(busy), .stall(stall),
        .done(done), .op_err(op_err), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 iterative, 1 move-to, 2 reserved/error
    function automatic void mdl(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] h, inout logic [31:0] l, output int kind);
        logic [63:0] p;
        int sx, sy;
        sx = x;
        sy = y;
        kind = 0;
        case (o)
            3'd0: begin p = longint'(sx) * longint'(sy); {h, l} = p; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; {h, l} = p; end
`ifdef EX_MULDIV_DIV_EN
            3'd2: begin
                if (y == 0) begin l = '1; h = x; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin l = x; h = 0; end
                else begin l = sx / sy; h = sx % sy; end
            end
            3'd3: begin
                if (y == 0) begin l = '1; h = x; end
                else begin l = x / y; h = x % y; end
            end
`endif
            3'd4: begin h = x; kind = 1; end
            3'd5: begin l = x; kind = 1; end
            default: kind = 2;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit flush10);
        logic [31:0] nh, nl;
        int kind;
        nh = exp_hi;
        nl = exp_lo;
        mdl(o, x, y, nh, nl, kind);
        start = 1'b1; op = o; a = x; b = y;
        #1 chk("stall_idle", stall, 0);
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
        if (kind == 1) begin
            #1;
            chk("mt_busy_done", {busy, done}, 2'b00);
            exp_hi = nh; exp_lo = nl;
            chk("mt_hilo", {hi, lo}, {exp_hi, exp_lo});
            tick();
            return;
        end
        if (kind == 2) begin
            #1;
            chk("err_pulse", {op_err, busy}, 2'b10);
            chk("err_hilo", {hi, lo}, {exp_hi, exp_lo});
            tick();
            chk("err_clear", op_err, 0);
            return;
        end
        for (int c = 1; c <= XLEN + 1; c++) begin
            start = 1'b0; mf_req = 1'b0; op = 3'd5;
            if (c == 5) start = 1'b1;
            if (c == XLEN + 1) mf_req = 1'b1;
            if (flush10 && c == 10) flush = 1'b1;
            #1;
            chk("run_busy_done", {busy, done, op_err}, 3'b100);
            if (c == 5 || c == XLEN + 1) chk("busy_stall", stall, 1);
            tick();
            if (flush10 && c == 10) begin
                flush = 1'b0;
                chk("flush_busy", busy, 0);
                for (int k = 0; k < XLEN + 4; k++) begin
                    chk("flush_no_done", done, 0);
                    tick();
                end
                chk("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
                return;
            end
        end
        start = 1'b0; mf_req = 1'b1;
        #1;
        chk("done_pulse", {busy, done, stall}, 3'b010);
        exp_hi = nh; exp_lo = nl;
        chk("result_hilo", {hi, lo}, {exp_hi, exp_lo});
        mf_req = 1'b0;
        tick();
        chk("done_clear", done, 0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        logic [31:0] corner [4];
        corner[0] = 32'h0; corner[1] = 32'h1;
        corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h8000_0000;

        #2;
        chk("reset_state", {busy, done, op_err, stall}, 4'b0000);
        chk("reset_hilo", {hi, lo}, 64'h0);
        tick();
        rst = 1'b0;
        tick();

        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(3'd0, -32'sd3, 32'd5, 0);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(3'd2, -32'sd7, 32'd2, 0);
        do_op(3'd3, 32'd7, 32'd0, 0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd5, 32'h1234, 32'h0, 0);
        chk("mtlo_lo", lo, 32'h1234);
        do_op(3'd0, 32'h0001_2345, 32'h0000_0777, 1);
        do_op(3'd6, 32'h5555, 32'h1, 0);
        do_op(3'd4, 32'hCAFE_0001, 32'h0, 0);

        // flush alongside start in IDLE discards the op
        start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; flush = 1'b0;
        #1 chk("flush_idle_discard", {busy, lo}, {1'b0, exp_lo});
        tick();

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            ry = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            do_op(ro, rx, ry, 0);
        end

        // asynchronous reset in the middle of an iterative op
`ifdef EX_MULDIV_DIV_EN
        start = 1'b1; op = 3'd3;
`else
        start = 1'b1; op = 3'd1;
`endif
        a = 32'd1000; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("async_reset", {busy, done, hi, lo}, 66'h0);
        tick();
        rst = 1'b0;
        exp_hi = '0; exp_lo = '0;
        tick();
        do_op(3'd1, 32'd3, 32'd4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
